// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the ctrl_seq instruction sequencer: opcodes, ALU codes,
// FSM states, decode classes and instruction field positions.
package ctrl_seq_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_INV  = 4'b0101;
   localparam logic [3:0] OP_LOAD = 4'b1000;
   localparam logic [3:0] OP_INC  = 4'b1010;
   localparam logic [3:0] OP_DEC  = 4'b1011;
   localparam logic [3:0] OP_HLT  = 4'b1100;
   localparam logic [3:0] OP_JNZ  = 4'b1110;
   localparam logic [3:0] OP_JMP  = 4'b1111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_INV = 3'b101;

   localparam int OP_LSB   = 12;
   localparam int DEST_LSB = 8;
   localparam int SRCA_LSB = 4;
   localparam int SRCB_LSB = 0;
   localparam int IMM_LSB  = 0;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      CLS_NOP, CLS_ALU2, CLS_ALU1, CLS_LOAD, CLS_JMP, CLS_JNZ, CLS_HLT
   } cls_e;

   // Source of ALU operand B for the single-operand instructions.
   typedef enum logic [1:0] {
      B_REG, B_ONE, B_ZERO
   } bsel_e;

endpackage

// File: rtl/ctrl_seq_if.sv
// Sequencer-to-datapath bus: instruction ROM, register file and ALU connections.
interface ctrl_seq_if #(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
);
   logic [PC_W-1:0]   pc;
   logic              ir_en;
   logic [15:0]       ir_data;
   logic [1:0]        reg_addr;
   logic              reg_rd;
   logic              reg_wr;
   logic [DATA_W-1:0] reg_wdata;
   logic [DATA_W-1:0] reg_rdata;
   logic [2:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_out;
   logic              alu_cy;
   logic              alu_zero;

   modport master (
      output pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata, alu_op, alu_a, alu_b,
      input  ir_data, reg_rdata, alu_out, alu_cy, alu_zero
   );

   modport slave (
      input  pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata, alu_op, alu_a, alu_b,
      output ir_data, reg_rdata, alu_out, alu_cy, alu_zero
   );
endinterface

// File: rtl/ctrl_seq_dec.sv
// Combinational instruction decoder for ctrl_seq. With CTRL_SEQ_ILLEGAL_TRAP_EN
// defined, undefined opcodes decode as a halt and raise the illegal output.
module ctrl_seq_dec
   import ctrl_seq_pkg::*;
(
   input  logic [15:0] ir,
   output cls_e        cls,
   output logic [2:0]  alu_op,
   output logic        a_from_dest,
   output bsel_e       b_sel,
   output logic [1:0]  dest,
   output logic [1:0]  src_a,
   output logic [1:0]  src_b,
   output logic [7:0]  imm
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   ,
   output logic        illegal
`endif
);

   logic unused_bits;
   assign unused_bits = ^ir[11:10];

   assign dest  = ir[DEST_LSB +: 2];
   assign src_a = ir[SRCA_LSB +: 2];
   assign src_b = ir[SRCB_LSB +: 2];
   assign imm   = ir[IMM_LSB  +: 8];

   always_comb begin
      // NOTE: every output gets a default before the case so no path infers a latch.
      cls         = CLS_NOP;
      alu_op      = ALU_ADD;
      a_from_dest = 1'b0;
      b_sel       = B_REG;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
      illegal     = 1'b0;
`endif
      case (ir[OP_LSB +: 4])
         OP_ADD:  cls = CLS_ALU2;
         OP_SUB:  begin cls = CLS_ALU2; alu_op = ALU_SUB; end
         OP_AND:  begin cls = CLS_ALU2; alu_op = ALU_AND; end
         OP_OR:   begin cls = CLS_ALU2; alu_op = ALU_OR;  end
         OP_XOR:  begin cls = CLS_ALU2; alu_op = ALU_XOR; end
         OP_INV:  begin cls = CLS_ALU1; alu_op = ALU_INV; b_sel = B_ZERO; end
         OP_LOAD: cls = CLS_LOAD;
         OP_INC:  begin cls = CLS_ALU1; alu_op = ALU_ADD; a_from_dest = 1'b1; b_sel = B_ONE; end
         OP_DEC:  begin cls = CLS_ALU1; alu_op = ALU_SUB; a_from_dest = 1'b1; b_sel = B_ONE; end
         OP_HLT:  cls = CLS_HLT;
         OP_JNZ:  begin cls = CLS_JNZ; a_from_dest = 1'b1; end
         OP_JMP:  cls = CLS_JMP;
         default: begin
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            cls     = CLS_HLT;
            illegal = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: fetch/decode/execute sequencer driving instruction ROM, register file and ALU.
// Optional trap on undefined opcodes via CTRL_SEQ_ILLEGAL_TRAP_EN (adds the illegal output).
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   ctrl_seq_if.master  bus,
   output logic        flag_c,
   output logic        flag_z,
   output logic        halted,
   output logic [15:0] retired
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   ,
   output logic        illegal
`endif
);

   state_e            state_q, state_d;
   logic [15:0]       ir_q, ir_d;
   logic [PC_W-1:0]   pc_q, pc_d, pc_inc, pc_tgt;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d, imm_w;
   logic              flag_c_q, flag_c_d, flag_z_q, flag_z_d;
   logic [15:0]       retired_q, retired_d, retired_inc;

   logic              fetch, reg_rd_c, reg_wr_c;
   logic [1:0]        reg_addr_c;
   logic [DATA_W-1:0] reg_wdata_c;

   cls_e              cls;
   logic [2:0]        dec_alu_op;
   logic              a_from_dest;
   bsel_e             b_sel;
   logic [1:0]        dest, src_a, src_b;
   logic [7:0]        imm;

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   logic              dec_illegal, illegal_q, illegal_d;
`endif

   ctrl_seq_dec u_dec (
      .ir          (ir_q),
      .cls         (cls),
      .alu_op      (dec_alu_op),
      .a_from_dest (a_from_dest),
      .b_sel       (b_sel),
      .dest        (dest),
      .src_a       (src_a),
      .src_b       (src_b),
      .imm         (imm)
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
      ,
      .illegal     (dec_illegal)
`endif
   );

   assign pc_inc      = pc_q + PC_W'(1);
   assign pc_tgt      = PC_W'(imm);
   assign imm_w       = DATA_W'(imm);
   assign retired_inc = retired_q + 16'd1;

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      pc_d        = pc_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      flag_c_d    = flag_c_q;
      flag_z_d    = flag_z_q;
      retired_d   = retired_q;
      fetch       = 1'b0;
      reg_rd_c    = 1'b0;
      reg_wr_c    = 1'b0;
      reg_addr_c  = '0;
      reg_wdata_c = '0;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
      illegal_d   = illegal_q;
`endif
      case (state_q)
         S_FETCH: begin
            fetch   = 1'b1;
            ir_d    = bus.ir_data;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (cls)
               CLS_LOAD: state_d = S_WRITE;
               CLS_JMP: begin
                  pc_d      = pc_tgt;
                  retired_d = retired_inc;
                  state_d   = S_FETCH;
               end
               CLS_HLT: begin
                  retired_d = retired_inc;
                  state_d   = S_HALT;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
                  illegal_d = illegal_q | dec_illegal;
`endif
               end
               CLS_NOP: begin
                  pc_d      = pc_inc;
                  retired_d = retired_inc;
                  state_d   = S_FETCH;
               end
               default: state_d = S_READ_A;
            endcase
         end
         S_READ_A: begin
            reg_rd_c   = 1'b1;
            reg_addr_c = a_from_dest ? dest : src_a;
            a_d        = bus.reg_rdata;
            if (cls == CLS_JNZ) begin
               pc_d      = (bus.reg_rdata != '0) ? pc_tgt : pc_inc;
               retired_d = retired_inc;
               state_d   = S_FETCH;
            end else if (cls == CLS_ALU1) begin
               // Single-operand ops take a constant B instead of a second register read.
               b_d     = (b_sel == B_ONE) ? DATA_W'(1) : '0;
               state_d = S_EXEC;
            end else begin
               state_d = S_READ_B;
            end
         end
         S_READ_B: begin
            reg_rd_c   = 1'b1;
            reg_addr_c = src_b;
            b_d        = bus.reg_rdata;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            res_d    = bus.alu_out;
            flag_c_d = bus.alu_cy;
            flag_z_d = bus.alu_zero;
            state_d  = S_WRITE;
         end
         S_WRITE: begin
            reg_wr_c    = 1'b1;
            reg_addr_c  = dest;
            reg_wdata_c = (cls == CLS_LOAD) ? imm_w : res_q;
            pc_d        = pc_inc;
            retired_d   = retired_inc;
            state_d     = S_FETCH;
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         ir_q      <= '0;
         pc_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
         retired_q <= '0;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         pc_q      <= pc_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         flag_c_q  <= flag_c_d;
         flag_z_q  <= flag_z_d;
         retired_q <= retired_d;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Fetch enable is qualified by reset so every output reads zero while held in reset.
   assign bus.ir_en     = fetch & rst_n;
   assign bus.pc        = pc_q;
   assign bus.reg_rd    = reg_rd_c;
   assign bus.reg_wr    = reg_wr_c;
   assign bus.reg_addr  = reg_addr_c;
   assign bus.reg_wdata = reg_wdata_c;
   assign bus.alu_op    = dec_alu_op;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;

   assign flag_c  = flag_c_q;
   assign flag_z  = flag_z_q;
   assign halted  = (state_q == S_HALT);
   assign retired = retired_q;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: ROM, register file and ALU around the DUT, checked per
// instruction against an instruction-level reference model.
module tb_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flag_c, flag_z, halted;
   logic [15:0] retired;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   always #5 clk = ~clk;

   ctrl_seq_if #(.PC_W(8), .DATA_W(8)) bus ();

   ctrl_seq #(.PC_W(8), .DATA_W(8)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .flag_c  (flag_c),
      .flag_z  (flag_z),
      .halted  (halted),
      .retired (retired)
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
      ,
      .illegal (illegal)
`endif
   );

   // Datapath environment: instruction ROM, register file, ALU.
   logic [15:0] rom [256];
   logic [7:0]  rf  [4] = '{default: 8'h00};

   assign bus.ir_data   = rom[bus.pc];
   assign bus.reg_rdata = bus.reg_rd ? rf[bus.reg_addr] : 8'h00;

   always @(posedge clk) begin
      if (bus.reg_wr) rf[bus.reg_addr] <= bus.reg_wdata;
   end

   function automatic logic [9:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] r;
      case (op)
         3'd0:    r = {1'b0, a} + {1'b0, b};
         3'd1:    r = {1'b0, a} - {1'b0, b};
         3'd2:    r = {1'b0, a & b};
         3'd3:    r = {1'b0, a | b};
         3'd4:    r = {1'b0, a ^ b};
         3'd5:    r = {1'b0, ~a};
         default: r = 9'd0;
      endcase
      return {r[8], r[7:0] == 8'h00, r[7:0]};
   endfunction

   assign {bus.alu_cy, bus.alu_zero, bus.alu_out} = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Instruction-level reference model.
   logic [7:0]  m_pc;
   logic [7:0]  m_regs [4] = '{default: 8'h00};
   logic        m_c, m_z, m_halted, m_illegal;
   logic [15:0] m_retired;

   task automatic model_reset();
      m_pc = 8'h00; m_c = 1'b0; m_z = 1'b0;
      m_halted = 1'b0; m_illegal = 1'b0; m_retired = 16'h0;
   endtask

   task automatic model_step(input logic [15:0] inst, output int lat, output bit wr,
                             output logic [1:0] wa, output logic [7:0] wd);
      logic [3:0] op;
      logic [1:0] d, sa, sb;
      logic [7:0] imm, next_pc, ra, rb;
      logic [8:0] r;
      bit         alu;
      op = inst[15:12]; d = inst[9:8]; sa = inst[5:4]; sb = inst[1:0]; imm = inst[7:0];
      ra = m_regs[sa]; rb = m_regs[sb];
      wr = 1'b0; wa = d; wd = 8'h00; alu = 1'b0; lat = 2; r = 9'd0;
      next_pc = m_pc + 8'd1;
      case (op)
         4'h0: begin r = {1'b0, ra} + {1'b0, rb}; alu = 1; lat = 6; end
         4'h1: begin r = {1'b0, ra} - {1'b0, rb}; alu = 1; lat = 6; end
         4'h2: begin r = {1'b0, ra & rb}; alu = 1; lat = 6; end
         4'h3: begin r = {1'b0, ra | rb}; alu = 1; lat = 6; end
         4'h4: begin r = {1'b0, ra ^ rb}; alu = 1; lat = 6; end
         4'h5: begin r = {1'b0, ~ra}; alu = 1; lat = 5; end
         4'h8: begin wr = 1; wd = imm; lat = 3; end
         4'hA: begin r = {1'b0, m_regs[d]} + 9'd1; alu = 1; lat = 5; end
         4'hB: begin r = {1'b0, m_regs[d]} - 9'd1; alu = 1; lat = 5; end
         4'hC: begin m_halted = 1; next_pc = m_pc; end
         4'hE: begin lat = 3; if (m_regs[d] != 8'h00) next_pc = imm; end
         4'hF: next_pc = imm;
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
         4'h6, 4'h7, 4'h9, 4'hD: begin m_halted = 1; m_illegal = 1; next_pc = m_pc; end
`endif
         default: ;
      endcase
      if (alu) begin
         wr = 1; wd = r[7:0]; m_c = r[8]; m_z = (r[7:0] == 8'h00);
      end
      if (wr) m_regs[wa] = wd;
      m_retired = m_retired + 16'd1;
      m_pc = next_pc;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pc"}, bus.pc, 0);
      check({tag, "_strobes"}, {bus.ir_en, bus.reg_rd, bus.reg_wr, halted}, 0);
      check({tag, "_bus"}, {bus.reg_addr, bus.reg_wdata, bus.alu_op, bus.alu_a, bus.alu_b}, 0);
      check({tag, "_state"}, {flag_c, flag_z, retired}, 0);
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
      check({tag, "_illegal"}, illegal, 0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      model_reset();
   endtask

   // Starts at the FETCH cycle of an instruction; runs until halt or max_instr instructions.
   task automatic run_prog(input int max_instr);
      int         lat, cyc, n_wr;
      bit         wr, both;
      logic [1:0] wa, got_a;
      logic [7:0] wd, got_d;
      for (int k = 0; k < max_instr; k++) begin
         check("fetch_pc", bus.pc, m_pc);
         check("fetch_en", {bus.ir_en, halted}, 2'b10);
         check("retired", retired, m_retired);
         check("flags", {flag_c, flag_z}, {m_c, m_z});
         model_step(rom[m_pc], lat, wr, wa, wd);
         cyc = 0; n_wr = 0; both = 0; got_a = 0; got_d = 0;
         do begin
            @(negedge clk);
            cyc++;
            if (bus.reg_wr) begin n_wr++; got_a = bus.reg_addr; got_d = bus.reg_wdata; end
            if (bus.reg_wr && bus.reg_rd) both = 1;
         end while (!bus.ir_en && !halted && cyc < 12);
         check("latency", cyc, lat);
         check("wr_count", n_wr, wr ? 1 : 0);
         if (wr) begin
            check("wr_addr", got_a, wa);
            check("wr_data", got_d, wd);
         end
         check("rd_wr_excl", both, 0);
         if (cyc >= 12) return;
         if (m_halted) begin
            check("halted", halted, 1);
            check("halt_pc", bus.pc, m_pc);
            check("halt_retired", retired, m_retired);
            check("halt_flags", {flag_c, flag_z}, {m_c, m_z});
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            check("illegal", illegal, m_illegal);
`endif
            both = 0;
            repeat (3) begin
               @(negedge clk);
               if (bus.ir_en || bus.reg_rd || bus.reg_wr || !halted) both = 1;
            end
            check("halt_absorbing", both, 0);
            return;
         end
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 16'hC000;
   endtask

   function automatic logic [15:0] rand_inst();
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:12] == 4'hC && $urandom_range(0, 3) != 0) w[15:12] = 4'hA;
      if ($urandom_range(0, 3) == 0) w[7:0] = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00;
      return w;
   endfunction

   initial begin
      bit saw_wr;
      clear_rom();

      // LOAD R0,5; LOAD R1,3; ADD R2,R0,R1; HLT
      rom[0] = 16'h8005; rom[1] = 16'h8103; rom[2] = 16'h0201;
      do_reset();
      run_prog(10);
      check("add_r2", rf[2], 8'h08);
      check("add_retired", retired, 16'd4);

      // LOAD R0,0xFF; INC R0; HLT
      clear_rom();
      rom[0] = 16'h80FF; rom[1] = 16'hA000;
      do_reset();
      run_prog(10);
      check("inc_r0", rf[0], 8'h00);
      check("inc_flags", {flag_c, flag_z}, 2'b11);

      // LOAD R3,3; loop: DEC R3; JNZ R3,loop; HLT
      clear_rom();
      rom[0] = 16'h8303; rom[1] = 16'hB300; rom[2] = 16'hE301;
      do_reset();
      run_prog(20);
      check("loop_r3", rf[3], 8'h00);
      check("loop_pc", bus.pc, 8'h03);

      // JMP 0xFE; NOP at 0xFE and 0xFF; pc wraps back to 0
      clear_rom();
      rom[0] = 16'hF0FE; rom[8'hFE] = 16'h6000; rom[8'hFF] = 16'h6000;
      do_reset();
      run_prog(4);

      // Undefined opcode at pc 0
      clear_rom();
      rom[0] = 16'h6000; rom[1] = 16'hC000;
      do_reset();
      run_prog(5);
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
      check("trap_pc", bus.pc, 8'h00);
`else
      check("nop_pc", bus.pc, 8'h01);
`endif

      // Reset asserted during EXEC of SUB R2,R0,R1
      clear_rom();
      rom[0] = 16'h8009; rom[1] = 16'h8104; rom[2] = 16'h1201;
      do_reset();
      run_prog(2);
      repeat (4) @(negedge clk);
      check("exec_alu", {bus.alu_op, bus.alu_a, bus.alu_b}, {3'b001, 8'h09, 8'h04});
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      saw_wr = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.reg_wr) saw_wr = 1;
      end
      check("midrst_no_wr", saw_wr, 0);
      check("midrst_r2", rf[2], m_regs[2]);
      rst_n = 1'b1;
      #1;
      model_reset();
      run_prog(10);

      // Randomized programs, each starting by loading all four registers
      for (int p = 0; p < 25; p++) begin
         for (int i = 0; i < 256; i++) rom[i] = rand_inst();
         for (int r = 0; r < 4; r++) rom[r] = {4'h8, 2'b00, 2'(r), 8'($urandom)};
         do_reset();
         run_prog(60);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Synthesizable sequencer that fetches, decodes and executes instructions.
- Drives the instruction ROM (`inst_reg`), the 4x8 register file (`registers`) and the 8-bit `alu`.
- Replaces the behavioural sequencing currently done in the top-level bench with real clocked control. One instruction completes in 2-6 cycles.

Parameters:
- PC_W, 8, program counter width; wraps modulo 2^PC_W.
- DATA_W, 8, datapath width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  out  PC_W  instruction address to `inst_reg`.
- ir_en  out  1  instruction fetch enable.
- ir_data  in  16  instruction word, combinational from `inst_reg`.
- reg_addr  out  2  register file address.
- reg_rd  out  1  register read strobe.
- reg_wr  out  1  register write strobe.
- reg_wdata  out  DATA_W  register write data.
- reg_rdata  in  DATA_W  register read data, combinational on reg_addr when reg_rd=1.
- alu_op  out  3  ALU opcode.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_out  in  DATA_W  ALU result.
- alu_cy  in  1  ALU carry.
- alu_zero  in  1  ALU zero.
- flag_c  out  1  latched carry.
- flag_z  out  1  latched zero.
- halted  out  1  high in HALT state.
- retired  out  16  instructions retired; wraps.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: pc=0, IR=0, all outputs 0, state=FETCH. Reset mid-instruction abandons it; no write is issued.
- Instruction fields: [15:12] op, [9:8] dest, [5:4] srcA, [1:0] srcB, [7:0] imm/target.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 INV (A only).
  - 1000 LOAD dest,imm; 1010 INC dest; 1011 DEC dest.
  - 1100 HLT; 1110 JNZ dest,target; 1111 JMP target.
  - All other opcodes are NOP.
- ALU op mapping: ADD=000, SUB=001, AND=010, OR=011, XOR=100, INV=101, INC→000 with B=1, DEC→001 with B=1, INV with B=0.
- States:
  - FETCH: ir_en=1, pc driven; IR<=ir_data at edge → DECODE.
  - DECODE:
    - LOAD → WRITE with wdata=imm.
    - JMP: pc<=imm → FETCH.
    - HLT → HALT.
    - NOP: pc<=pc+1 → FETCH.
    - ALU ops and JNZ → READ_A.
  - READ_A: reg_rd=1; reg_addr=srcA, or dest for INC/DEC/JNZ; A<=reg_rdata.
    - JNZ: pc<=(rdata!=0)?imm:pc+1 → FETCH.
    - INC/DEC/INV → EXEC.
    - Others → READ_B.
  - READ_B: reg_rd=1, reg_addr=srcB, B<=reg_rdata → EXEC.
  - EXEC: alu_op/alu_a/alu_b stable; result<=alu_out; flag_c<=alu_cy; flag_z<=alu_zero → WRITE.
  - WRITE: reg_wr=1 for exactly one cycle, reg_addr=dest, reg_wdata=result (or imm for LOAD); pc<=pc+1 → FETCH.
  - HALT: halted=1, all strobes 0; absorbing until reset.
- Strobe rules: reg_rd and reg_wr are never high in the same cycle. Flags change only in EXEC.
- retired increments:
  - on WRITE exit;
  - on JMP, NOP and JNZ resolution;
  - on HALT entry.
- Latencies (cycles):
  - LOAD 3, JMP 2, NOP 2, JNZ 3, HLT 2 to halted.
  - INC/DEC/INV 5, two-operand ops 6.
- pc wraps 2^PC_W-1 → 0 on increment. JMP/JNZ target is imm truncated to PC_W.

Optional Feature:
- Macro: CTRL_SEQ_ILLEGAL_TRAP_EN.
- When defined: the undefined opcodes 0110, 0111, 1001 and 1101 enter HALT, and an extra output `illegal` (1 bit, reset 0) sets and holds.
- When undefined: those opcodes execute as NOP and no `illegal` port exists.

Decomposition:
- Package ctrl_seq_pkg holds:
  - 4-bit opcode localparams;
  - 3-bit ALU op codes;
  - state encoding (FETCH, DECODE, READ_A, READ_B, EXEC, WRITE, HALT);
  - instruction field bit positions.
- One combinational sub-module, ctrl_seq_dec: maps IR to class (alu2, alu1, load, jmp, jnz, hlt, nop), alu_op, read-address selects and the B=1/B=0 override.

Test Plan:
- LOAD R0,5; LOAD R1,3; ADD R2,R0,R1 → reg_wr at addr 2 with wdata 8, flag_c=0, flag_z=0; ADD completes in 6 cycles; retired=3.
- LOAD R0,0xFF; INC R0 → writes 0x00, flag_c=1, flag_z=1.
- LOAD R3,3; loop DEC R3; JNZ R3,loop; HLT → DEC executes 3 times, R3 final 0, halted=1, pc holds at HLT address.
- JMP 0xFE at pc 0; NOP at 0xFE and 0xFF → pc sequence 0, FE, FF, 00.
- Assert rst_n low during EXEC of SUB → no reg_wr issued, all outputs 0 immediately; after release, fetch resumes at pc 0.
- Opcode 0110 at pc 0 → with macro: halted=1, illegal=1; without macro: pc advances to 1, no register write.
